// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract front end.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fp_pkg;

  // Default formats. Field positions for any format are: fraction at
  // [MAN_W-1:0], exponent at [MAN_W+EXP_W-1:MAN_W], sign at MSB.
  localparam int unsigned SP_EXP_W = 8;
  localparam int unsigned SP_MAN_W = 23;
  localparam int unsigned HP_EXP_W = 5;
  localparam int unsigned HP_MAN_W = 10;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_DENORM,
    FP_NORMAL,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_e;

  // Canonical quiet NaN (sign 0, exponent all ones, fraction MSB set),
  // returned right-aligned in a 64-bit word; callers slice to their width.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w,
                                          input int unsigned man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one operand: class, hidden bit, effective exponent.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows its inputs.
// Ports: exp_i/frac_i = exponent and fraction fields; cls_o = operand class;
//        hidden_o = implicit significand bit; eff_exp_o = biased exponent
//        with denormals/zeros mapped to 1.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W-1:0] frac_i,
  output fp_class_e        cls_o,
  output logic             hidden_o,
  output logic [EXP_W-1:0] eff_exp_o
);

  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  assign exp_zero  = (exp_i == '0);
  assign exp_ones  = (exp_i == '1);
  assign frac_zero = (frac_i == '0);

  always_comb begin
    cls_o = FP_NORMAL;
    if (exp_zero) begin
      cls_o = frac_zero ? FP_ZERO : FP_DENORM;
    end else if (exp_ones) begin
      if (frac_zero) begin
        cls_o = FP_INF;
      end else if (frac_i[MAN_W-1]) begin
        cls_o = FP_QNAN;
      end else begin
        cls_o = FP_SNAN;
      end
    end
  end

  // Denormals share the scale of the smallest normal, hence exponent 1.
  assign hidden_o  = ~exp_zero;
  assign eff_exp_o = exp_zero ? EXP_W'(1) : exp_i;

endmodule

// File: rtl/fp_unpack_align.sv
// Operand unpack/compare stage: classify, order by magnitude, alignment shift.
// Latency: 1 cycle from input handshake to out_valid; 1 bundle/cycle.
// Backpressure: output register + one-entry skid; in_ready is registered and
//               drops only while the skid entry holds a bundle.
// Ports: in_valid/in_ready/in_a/in_b/in_op = input handshake and operands;
//        out_valid/out_ready = output handshake; out_* = aligned bundle.
module fp_unpack_align
  import fp_pkg::*;
#(
  parameter int EXP_W = SP_EXP_W,
  parameter int MAN_W = SP_MAN_W,
  parameter int W     = 1 + EXP_W + MAN_W,
  parameter int SH_W  = $clog2(MAN_W + 4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_big_sign,
  output logic             out_small_sign,
  output logic [EXP_W-1:0] out_big_exp,
  output logic [MAN_W:0]   out_big_man,
  output logic [MAN_W:0]   out_small_man,
  output logic [SH_W-1:0]  out_shift,
  output logic             out_eff_sub,
  output logic             out_swapped,
  output logic             out_special,
  output logic [W-1:0]     out_special_res,
  output logic             out_invalid
);

  typedef struct packed {
    logic             big_sign;
    logic             small_sign;
    logic [EXP_W-1:0] big_exp;
    logic [MAN_W:0]   big_man;
    logic [MAN_W:0]   small_man;
    logic [SH_W-1:0]  shift;
    logic             eff_sub;
    logic             swapped;
    logic             special;
    logic [W-1:0]     special_res;
    logic             invalid;
  } bundle_t;

  localparam logic [63:0]    QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]   QNAN      = QNAN_WIDE[W-1:0];
  localparam logic [W-2:0]   INF_MAG   = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [EXP_W:0] SH_SAT    = (EXP_W + 1)'(MAN_W + 3);

  // ---------------- operand unpack ----------------
  logic             a_sign, b_sign_eff;
  logic [W-2:0]     a_mag, b_mag;
  fp_class_e        a_cls, b_cls;
  logic             a_hid, b_hid;
  logic [EXP_W-1:0] a_eexp, b_eexp;

  assign a_sign     = in_a[W-1];
  assign b_sign_eff = in_b[W-1] ^ in_op;
  assign a_mag      = in_a[W-2:0];
  assign b_mag      = in_b[W-2:0];

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .exp_i     (in_a[W-2:MAN_W]),
    .frac_i    (in_a[MAN_W-1:0]),
    .cls_o     (a_cls),
    .hidden_o  (a_hid),
    .eff_exp_o (a_eexp)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .exp_i     (in_b[W-2:MAN_W]),
    .frac_i    (in_b[MAN_W-1:0]),
    .cls_o     (b_cls),
    .hidden_o  (b_hid),
    .eff_exp_o (b_eexp)
  );

  // ---------------- compare, shift, specials ----------------
  logic             swap;
  logic [EXP_W-1:0] small_eexp;
  logic [EXP_W:0]   exp_diff;
  logic             a_nan, b_nan, a_inf, b_inf;
  bundle_t          nxt;

  assign swap  = (b_mag > a_mag);
  assign a_nan = (a_cls == FP_QNAN) || (a_cls == FP_SNAN);
  assign b_nan = (b_cls == FP_QNAN) || (b_cls == FP_SNAN);
  assign a_inf = (a_cls == FP_INF);
  assign b_inf = (b_cls == FP_INF);

  // Magnitude order implies eff_exp_big >= eff_exp_small, so the extra bit
  // only guards against wrap; it never goes negative.
  assign small_eexp = swap ? a_eexp : b_eexp;

  always_comb begin
    nxt            = '0;
    nxt.big_sign   = swap ? b_sign_eff : a_sign;
    nxt.small_sign = swap ? a_sign : b_sign_eff;
    nxt.big_exp    = swap ? b_eexp : a_eexp;
    nxt.big_man    = swap ? {b_hid, in_b[MAN_W-1:0]} : {a_hid, in_a[MAN_W-1:0]};
    nxt.small_man  = swap ? {a_hid, in_a[MAN_W-1:0]} : {b_hid, in_b[MAN_W-1:0]};
    nxt.eff_sub    = a_sign ^ b_sign_eff;
    nxt.swapped    = swap;

    exp_diff = {1'b0, nxt.big_exp} - {1'b0, small_eexp};
    if (exp_diff > SH_SAT) begin
      nxt.shift = SH_SAT[SH_W-1:0];
    end else begin
      nxt.shift = exp_diff[SH_W-1:0];
    end

    if (a_nan || b_nan) begin
      nxt.special     = 1'b1;
      nxt.special_res = QNAN;
      nxt.invalid     = (a_cls == FP_SNAN) || (b_cls == FP_SNAN);
    end else if (a_inf && b_inf && nxt.eff_sub) begin
      nxt.special     = 1'b1;
      nxt.special_res = QNAN;
      nxt.invalid     = 1'b1;
    end else if (a_inf) begin
      nxt.special     = 1'b1;
      nxt.special_res = {a_sign, INF_MAG};
    end else if (b_inf) begin
      nxt.special     = 1'b1;
      nxt.special_res = {b_sign_eff, INF_MAG};
    end
  end

  // ---------------- output register + skid ----------------
  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_vld_q, out_vld_d;
  logic    skid_vld_q, skid_vld_d;
  logic    in_rdy_q, in_rdy_d;
  logic    accept;

  assign accept = in_valid & in_rdy_q;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || out_ready) begin
      // Output register frees up: drain the skid first to keep order.
      // accept cannot be high here while the skid is full.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = accept;
        if (accept) begin
          out_d = nxt;
        end
      end
    end else if (accept) begin
      skid_d     = nxt;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready        = in_rdy_q;
  assign out_valid       = out_vld_q;
  assign out_big_sign    = out_q.big_sign;
  assign out_small_sign  = out_q.small_sign;
  assign out_big_exp     = out_q.big_exp;
  assign out_big_man     = out_q.big_man;
  assign out_small_man   = out_q.small_man;
  assign out_shift       = out_q.shift;
  assign out_eff_sub     = out_q.eff_sub;
  assign out_swapped     = out_q.swapped;
  assign out_special     = out_q.special;
  assign out_special_res = out_q.special_res;
  assign out_invalid     = out_q.invalid;

endmodule
